occ_data_path_arb: RTL
======================

Name: occ_data_path_arb

Overview:
- Parametrised successor of the fixed 4-port Occ data path.
- Serves N_CH accelerator read channels from one shared Occ ROM port.
- Uses round-robin arbitration and a channel-tag pipeline, so each returned word reaches only the channel that requested it.
- Adds per-channel busy/backpressure, an overflow error flag and a configurable ROM latency. The old block had none of these.

Parameters:
- N_CH, 4, number of requesting channels (1..16)
- ADDR_W, 8, Occ ROM address width
- DATA_W, 32, Occ ROM data width
- ROM_LAT, 1, ROM read latency in cycles (1..4)
- CH_W, $clog2(N_CH) (min 1), channel tag width (derived, not overridable)

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  reset, asynchronous, active-high
- storage_ce  in  N_CH  per-channel read request pulse
- storage_addr  in  N_CH*ADDR_W  per-channel address; channel i uses bits [i*ADDR_W +: ADDR_W]
- busy  out  N_CH  channel has a request pending or in flight
- data_to_alu  out  N_CH*DATA_W  per-channel returned word, registered
- done  out  N_CH  one-cycle pulse: data_to_alu slice for that channel is valid
- rom_ce  out  1  shared ROM read enable, registered
- rom_addr  out  ADDR_W  shared ROM address, registered
- rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after the edge that samples rom_ce
- ovf_err  out  1  sticky flag: a request arrived on a busy channel

Behaviour:
- Reset (asynchronous, rst high):
  - Clears pend, latched addresses, the tag pipeline and the RR pointer (pointer resets to 0).
  - Outputs go to: busy=0, done=0, data_to_alu=0, rom_ce=0, rom_addr=0, ovf_err=0.
- Reset mid-operation: in-flight reads are discarded, no done is issued, and data arriving after reset is ignored.
- Accept:
  - At edge E0, storage_ce[i]=1 with busy[i]=0 sets pend[i] and latches addr[i].
  - storage_ce[i]=1 with busy[i]=1 is dropped and ovf_err is set; it stays set until reset.
- busy[i] = pend[i] OR (tag stage valid with id i) OR done[i]. Each channel therefore has at most one outstanding read.
- Arbitration:
  - Combinational over pend[] in the cycle after E0. Picks the first pending channel at or after the RR pointer, wrapping modulo N_CH.
  - At edge E0+1: rom_ce=1, rom_addr=addr[g], pend[g]=0, tag stage 0 = {valid, g}, RR pointer = (g+1) mod N_CH.
  - With no pend set: rom_ce=0, tag stage 0 invalid, pointer unchanged.
- Throughput: at most one grant per cycle; the ROM is never issued two addresses in one cycle.
- Tag pipeline: stages 0..ROM_LAT, shifted each edge. At edge E0+2+ROM_LAT a valid stage ROM_LAT with id c does two things:
  - captures rom_data into the data_to_alu slice c;
  - pulses done[c] for one cycle.
- Latency, uncontested: done is high in the cycle after edge E0+2+ROM_LAT. With ROM_LAT=1 that is 3 edges after acceptance.
- data_to_alu slices hold their last value until that channel's next capture.
- Simultaneous requests on k idle channels are granted in k consecutive cycles in RR order. Each channel gets exactly one done.
- A new storage_ce on a channel in the same cycle its done is high is dropped (busy). It may be re-issued one cycle later.
- rom_data is ignored when no tag stage ROM_LAT is valid.

Decomposition:
- Shared package occ_pkg holds the OCC_ADDR_W/OCC_DATA_W defaults and the channel-tag struct {valid, id}.
- One sub-module, rr_arbiter: N_CH-wide round-robin, request vector + pointer in, one-hot grant + encoded id out, purely combinational.
- The pointer register stays in occ_data_path_arb.

Test Plan:
- Reset, then ce[0]=1, addr0=8'h05, ROM_LAT=1, ROM returns 32'hA5A5_0005:
  - rom_ce high 1 edge after accept, rom_addr=8'h05;
  - done[0] pulse 3 edges after accept, data_to_alu[31:0]=32'hA5A5_0005;
  - busy[0] high from accept through done.
- ce on all 4 channels in the same cycle, addrs 8'h10..8'h13:
  - rom_addr sequence 10,11,12,13 on consecutive cycles;
  - done[0..3] in order, each slice carries its own word.
- Fairness: ch0 and ch2 re-request immediately after each done, then ch1 requests. ch1 is granted within 2 grants of its request; no starvation over 100 cycles.
- ce[1] re-asserted while busy[1]=1: request dropped, ovf_err=1 and sticky, only one done[1] issued.
- ROM_LAT=3 build, single request: done 5 edges after accept, value correct.
- rst asserted between rom_ce and done: no done pulse, all outputs 0 immediately. A post-reset request completes normally.

Source files
------------

// File: rtl/occ_pkg.sv
// Shared Occ data-path definitions: default ROM geometry and the channel tag
// carried alongside each outstanding ROM read.
package occ_pkg;

   localparam int OCC_ADDR_W = 8;
   localparam int OCC_DATA_W = 32;
   localparam int OCC_ID_W   = 4;

   // id is sized for the largest channel count; narrower builds use the low bits.
   typedef struct packed {
      logic                valid;
      logic [OCC_ID_W-1:0] id;
   } occ_tag_t;

endpackage

// File: rtl/occ_data_path_arb_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping modulo N_CH.
module rr_arbiter #(
   parameter int  N_CH = 4,
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic [N_CH-1:0] req_i,
   input  logic [CH_W-1:0] ptr_i,
   output logic [N_CH-1:0] gnt_o,
   output logic [CH_W-1:0] gnt_id_o,
   output logic            gnt_vld_o
);

   logic [CH_W-1:0] idx;

   always_comb begin
      gnt_o     = '0;
      gnt_id_o  = '0;
      gnt_vld_o = 1'b0;
      idx       = '0;
      for (int k = 0; k < N_CH; k++) begin
         idx = CH_W'((int'(ptr_i) + k) % N_CH);
         if (!gnt_vld_o && req_i[idx]) begin
            gnt_vld_o  = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_id_o   = idx;
         end
      end
   end

endmodule

// File: rtl/occ_data_path_arb.sv
// Shares one Occ ROM read port among N_CH channels; a tag pipeline matching the
// ROM latency steers each returned word back to the channel that asked for it.
module occ_data_path_arb
   import occ_pkg::*;
#(
   parameter int  N_CH    = 4,
   parameter int  ADDR_W  = OCC_ADDR_W,
   parameter int  DATA_W  = OCC_DATA_W,
   parameter int  ROM_LAT = 1,
   localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH-1:0]          storage_ce,
   input  logic [N_CH*ADDR_W-1:0]   storage_addr,
   output logic [N_CH-1:0]          busy,
   output logic [N_CH*DATA_W-1:0]   data_to_alu,
   output logic [N_CH-1:0]          done,
   output logic                     rom_ce,
   output logic [ADDR_W-1:0]        rom_addr,
   input  logic [DATA_W-1:0]        rom_data,
   output logic                     ovf_err
);

   logic [N_CH-1:0]        pend_q, pend_d, accept, gnt, done_q;
   logic [ADDR_W-1:0]      addr_q [N_CH];
   occ_tag_t               tag_q [ROM_LAT+1];
   logic [CH_W-1:0]        ptr_q, ptr_d, gnt_id, cap_id;
   logic                   gnt_vld;
   logic [N_CH*DATA_W-1:0] data_q;
   logic                   rom_ce_q;
   logic [ADDR_W-1:0]      rom_addr_q;
   logic                   ovf_q, ovf_d;

   rr_arbiter #(.N_CH(N_CH)) u_rr (
      .req_i     (pend_q),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt),
      .gnt_id_o  (gnt_id),
      .gnt_vld_o (gnt_vld)
   );

   // A channel stays busy from acceptance until its done cycle ends, which
   // limits every channel to a single outstanding read.
   for (genvar gi = 0; gi < N_CH; gi++) begin : g_busy
      logic inflight;
      always_comb begin
         inflight = 1'b0;
         for (int s = 0; s <= ROM_LAT; s++) begin
            if (tag_q[s].valid && tag_q[s].id == OCC_ID_W'(gi)) inflight = 1'b1;
         end
      end
      assign busy[gi] = pend_q[gi] | inflight | done_q[gi];
   end

   always_comb begin
      accept = storage_ce & ~busy;
      pend_d = (pend_q & ~gnt) | accept;
      ovf_d  = ovf_q | (|(storage_ce & busy));
      ptr_d  = ptr_q;
      if (gnt_vld) ptr_d = (gnt_id == CH_W'(N_CH - 1)) ? '0 : gnt_id + CH_W'(1);
      cap_id = CH_W'(tag_q[ROM_LAT].id);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q     <= '0;
         ptr_q      <= '0;
         done_q     <= '0;
         data_q     <= '0;
         rom_ce_q   <= 1'b0;
         rom_addr_q <= '0;
         ovf_q      <= 1'b0;
         for (int c = 0; c < N_CH; c++) addr_q[c] <= '0;
         for (int s = 0; s <= ROM_LAT; s++) tag_q[s] <= '0;
      end else begin
         pend_q   <= pend_d;
         ptr_q    <= ptr_d;
         ovf_q    <= ovf_d;
         rom_ce_q <= gnt_vld;
         if (gnt_vld) rom_addr_q <= addr_q[gnt_id];
         tag_q[0] <= '{valid: gnt_vld, id: OCC_ID_W'(gnt_id)};
         for (int s = 1; s <= ROM_LAT; s++) tag_q[s] <= tag_q[s-1];
         // The last tag stage lines up with rom_data for the read it describes.
         for (int c = 0; c < N_CH; c++) begin
            if (accept[c]) addr_q[c] <= storage_addr[c*ADDR_W +: ADDR_W];
            done_q[c] <= tag_q[ROM_LAT].valid && (cap_id == CH_W'(c));
            if (tag_q[ROM_LAT].valid && (cap_id == CH_W'(c)))
               data_q[c*DATA_W +: DATA_W] <= rom_data;
         end
      end
   end

   assign done        = done_q;
   assign data_to_alu = data_q;
   assign rom_ce      = rom_ce_q;
   assign rom_addr    = rom_addr_q;
   assign ovf_err     = ovf_q;

endmodule
